// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, operand-source codes,
// FSM states and the shift-amount width helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_NOT = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  localparam logic [1:0] SEL_REG_IMM = 2'b00;
  localparam logic [1:0] SEL_PC_REL  = 2'b01;
  localparam logic [1:0] SEL_REG_REG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int SHAMT_W   = $clog2(DEF_WIDTH);

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Operand selection: register, sign-extended immediate or zero-extended PC
// onto the A/B operand buses.
module alu_operand_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMM_W = 6,
  parameter int PC_W  = 6
) (
  input  logic [1:0]       source_sel,
  input  logic [IMM_W-1:0] ins_immediate,
  input  logic [PC_W-1:0]  pc,
  input  logic [WIDTH-1:0] reg_sr1_out,
  input  logic [WIDTH-1:0] reg_sr2_out,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b
);

  // Signed views so the size casts below sign-extend.
  logic signed [IMM_W-2:0] imm_short;
  logic signed [IMM_W-1:0] imm_full;

  assign imm_short = ins_immediate[IMM_W-2:0];
  assign imm_full  = ins_immediate;

  always_comb begin
    op_a = reg_sr1_out;
    op_b = reg_sr2_out;
    case (source_sel)
      SEL_REG_IMM: op_b = WIDTH'(imm_short);
      SEL_PC_REL: begin
        op_a = WIDTH'(pc);
        op_b = WIDTH'(imm_full);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/logic, iterative shifts (1 bit/cycle) and
// shift-add multiply, with registered result and NZP held for the branch unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMM_W = 6,
  parameter int PC_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       source_sel,
  input  logic [IMM_W-1:0] ins_immediate,
  input  logic [PC_W-1:0]  pc,
  input  logic [WIDTH-1:0] reg_sr1_out,
  input  logic [WIDTH-1:0] reg_sr2_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             positive,
  output logic             busy
);

  localparam int SH_W = shamt_width(WIDTH);

  state_e           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic [SH_W:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             negative_reg, zero_reg, positive_reg;

  logic [WIDTH-1:0] op_a, op_b;
  logic [SH_W-1:0]  shamt;
  logic             accept, single, last_step, load_result;
  logic [WIDTH-1:0] quick_result, step_a, step_acc, new_result;

  alu_operand_mux #(
    .WIDTH(WIDTH),
    .IMM_W(IMM_W),
    .PC_W (PC_W)
  ) u_operand_mux (
    .source_sel   (source_sel),
    .ins_immediate(ins_immediate),
    .pc           (pc),
    .reg_sr1_out  (reg_sr1_out),
    .reg_sr2_out  (reg_sr2_out),
    .op_a         (op_a),
    .op_b         (op_b)
  );

  assign shamt     = op_b[SH_W-1:0];
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_CALC);

  // A shift by zero has nothing to iterate, so it retires like a logic op.
  assign single = (alu_op != OP_MUL) &&
                  (((alu_op != OP_SHL) && (alu_op != OP_SRA)) || (shamt == '0));

  always_comb begin
    quick_result = op_a;
    case (alu_op)
      OP_ADD:  quick_result = op_a + op_b;
      OP_AND:  quick_result = op_a & op_b;
      OP_NOT:  quick_result = (source_sel == SEL_REG_IMM) ? ~op_b : ~op_a;
      OP_OR:   quick_result = op_a | op_b;
      OP_XOR:  quick_result = op_a ^ op_b;
      default: quick_result = op_a;
    endcase
  end

  // One iteration: a_reg doubles as the shifting operand and the MUL multiplicand.
  assign step_a    = (op_reg == OP_SRA) ? {a_reg[WIDTH-1], a_reg[WIDTH-1:1]} : (a_reg << 1);
  assign step_acc  = acc_reg + (b_reg[0] ? a_reg : '0);
  assign last_step = (cnt_reg == (SH_W+1)'(1));

  assign load_result = (accept && single) || ((state_reg == ST_CALC) && last_step);
  assign new_result  = (state_reg == ST_CALC) ? ((op_reg == OP_MUL) ? step_acc : step_a)
                                              : quick_result;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = single ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_next = ST_DONE;
      ST_DONE: begin
        if (accept)         state_next = single ? ST_DONE : ST_CALC;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      negative_reg <= 1'b0;
      zero_reg     <= 1'b1;
      positive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_result) begin
        result_reg   <= new_result;
        negative_reg <= new_result[WIDTH-1];
        zero_reg     <= (new_result == '0);
        positive_reg <= !new_result[WIDTH-1] && (new_result != '0);
      end
      if (accept && !single) begin
        op_reg  <= alu_op;
        a_reg   <= op_a;
        b_reg   <= op_b;
        acc_reg <= '0;
        cnt_reg <= (alu_op == OP_MUL) ? (SH_W+1)'(WIDTH) : {1'b0, shamt};
      end else if (state_reg == ST_CALC) begin
        a_reg   <= step_a;
        b_reg   <= b_reg >> 1;
        acc_reg <= step_acc;
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign result   = result_reg;
  assign negative = negative_reg;
  assign zero     = zero_reg;
  assign positive = positive_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: vector table, multi-cycle corner sequences and
// a randomized pass checked against an independent reference model.
module tb_alu_mc;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] alu_op;
  logic [1:0] source_sel;
  logic [5:0] ins_immediate, pc;
  logic [7:0] reg_sr1_out, reg_sr2_out, result;
  logic       negative, zero, positive, busy;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8), .IMM_W(6), .PC_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .source_sel   (source_sel),
    .ins_immediate(ins_immediate),
    .pc           (pc),
    .reg_sr1_out  (reg_sr1_out),
    .reg_sr2_out  (reg_sr2_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .negative     (negative),
    .zero         (zero),
    .positive     (positive),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] result;
    int         lat;
    int         acc_cyc;
  } sb_t;

  typedef struct {
    logic [2:0] op;
    logic [1:0] sel;
    logic [5:0] imm;
    logic [5:0] pcv;
    logic [7:0] sr1;
    logic [7:0] sr2;
    logic [7:0] exp_result;
    int         exp_lat;
  } vec_t;

  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_txn = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] nzp(input logic [7:0] r);
    return {r[7], r == 8'h00, !r[7] && (r != 8'h00)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: latency on first presentation, value/flags every valid cycle.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out_valid: got result %h with no pending op (cycle %0d)", result, cyc);
      end else begin
        if (!seen) begin
          chk("latency", cyc - sb_q[0].acc_cyc, sb_q[0].lat);
          seen = 1;
        end
        chk("result", result, sb_q[0].result);
        chk("nzp", {negative, zero, positive}, nzp(sb_q[0].result));
        if (out_ready) begin
          n_txn++;
          $display("txn %0d: result=%h nzp=%b expected=%h lat=%0d", n_txn, result,
                   {negative, zero, positive}, sb_q[0].result, sb_q[0].lat);
          void'(sb_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] sel, input logic [5:0] imm,
                       input logic [5:0] pcv, input logic [7:0] sr1, input logic [7:0] sr2,
                       input logic [7:0] exp_r, input int exp_lat);
    sb_t e;
    alu_op = op; source_sel = sel; ins_immediate = imm; pc = pcv;
    reg_sr1_out = sr1; reg_sr2_out = sr2;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.result = exp_r; e.lat = exp_lat; e.acc_cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL issue_timeout: in_ready never rose for op %b", op);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    chk("drain", sb_q.size(), 0);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [1:0] sel,
                                       input logic [5:0] imm, input logic [5:0] pcv,
                                       input logic [7:0] sr1, input logic [7:0] sr2,
                                       output int lat);
    logic [7:0] a, b, r;
    a = sr1;
    b = sr2;
    if (sel == 2'b00) b = {{3{imm[4]}}, imm[4:0]};
    else if (sel == 2'b01) begin
      a = {2'b00, pcv};
      b = {{2{imm[5]}}, imm};
    end
    lat = 1;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a & b;
      3'b010: r = (sel == 2'b00) ? ~b : ~a;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: begin r = a << b[2:0]; lat = b[2:0] + 1; end
      3'b110: begin r = $signed(a) >>> b[2:0]; lat = b[2:0] + 1; end
      default: begin r = a * b; lat = 9; end
    endcase
    return r;
  endfunction

  vec_t vecs[15];

  initial begin
    int c0, c1, c2, lat;
    logic [7:0] r, held;
    logic [2:0] rop;
    logic [1:0] rsel;
    logic [5:0] rimm, rpc;
    logic [7:0] rs1, rs2;

    vecs = '{
      '{3'b000, 2'b00, 6'b010100, 6'd0,  8'h34, 8'h00, 8'h28, 1},
      '{3'b000, 2'b01, 6'b010100, 6'd28, 8'h00, 8'h00, 8'h30, 1},
      '{3'b010, 2'b10, 6'b000000, 6'd0,  8'h34, 8'h00, 8'hCB, 1},
      '{3'b010, 2'b00, 6'b010100, 6'd0,  8'h00, 8'h00, 8'h0B, 1},
      '{3'b110, 2'b10, 6'b000000, 6'd0,  8'h90, 8'h0B, 8'hF2, 4},
      '{3'b110, 2'b10, 6'b000000, 6'd0,  8'h90, 8'h08, 8'h90, 1},
      '{3'b101, 2'b00, 6'b000010, 6'd0,  8'h03, 8'h00, 8'h0C, 3},
      '{3'b101, 2'b10, 6'b000000, 6'd0,  8'h81, 8'hF9, 8'h02, 2},
      '{3'b001, 2'b11, 6'b000000, 6'd0,  8'hF0, 8'h3C, 8'h30, 1},
      '{3'b011, 2'b10, 6'b000000, 6'd0,  8'h0F, 8'h30, 8'h3F, 1},
      '{3'b100, 2'b10, 6'b000000, 6'd0,  8'hAA, 8'hAA, 8'h00, 1},
      '{3'b111, 2'b00, 6'b011111, 6'd0,  8'h05, 8'h00, 8'hFB, 9},
      '{3'b000, 2'b01, 6'b100000, 6'd63, 8'h00, 8'h00, 8'h1F, 1},
      '{3'b110, 2'b10, 6'b000000, 6'd0,  8'h40, 8'h07, 8'h00, 8},
      '{3'b010, 2'b01, 6'b000000, 6'h15, 8'h00, 8'h00, 8'hEA, 1}
    };

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; source_sel = '0; ins_immediate = '0; pc = '0;
    reg_sr1_out = '0; reg_sr2_out = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 8'h00);
    chk("rst_nzp", {negative, zero, positive}, 3'b010);
    @(posedge clk); #1;

    foreach (vecs[i])
      issue(vecs[i].op, vecs[i].sel, vecs[i].imm, vecs[i].pcv, vecs[i].sr1, vecs[i].sr2,
            vecs[i].exp_result, vecs[i].exp_lat);
    drain();

    // MUL: busy and not ready for exactly WIDTH cycles.
    issue(3'b111, 2'b10, 6'd0, 6'd0, 8'h0D, 8'h13, 8'hF7, 9);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      chk("mul_out_valid", out_valid, 0);
    end
    drain();

    // Result held while the consumer stalls, then three back-to-back ADDs.
    out_ready = 1'b0;
    issue(3'b000, 2'b10, 6'd0, 6'd0, 8'h11, 8'h22, 8'h33, 1);
    @(negedge clk);
    held = result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_stable", result, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'b000, 2'b10, 6'd0, 6'd0, 8'h01, 8'h02, 8'h03, 1); c0 = cyc;
    issue(3'b000, 2'b10, 6'd0, 6'd0, 8'h7F, 8'h01, 8'h80, 1); c1 = cyc;
    issue(3'b000, 2'b10, 6'd0, 6'd0, 8'hFF, 8'h01, 8'h00, 1); c2 = cyc;
    chk("b2b_gap1", c1 - c0, 1);
    chk("b2b_gap2", c2 - c1, 1);
    drain();

    // Reset on the 4th CALC cycle of a MUL discards it.
    issue(3'b111, 2'b10, 6'd0, 6'd0, 8'h0D, 8'h13, 8'hF7, 9);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    seen = 0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 8'h00);
    chk("abort_nzp", {negative, zero, positive}, 3'b010);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    issue(3'b000, 2'b00, 6'b010100, 6'd0, 8'h34, 8'h00, 8'h28, 1);
    drain();

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rsel = 2'($urandom_range(0, 3));
      rimm = 6'($urandom); rpc = 6'($urandom);
      rs1 = 8'($urandom); rs2 = 8'($urandom);
      r = model(rop, rsel, rimm, rpc, rs1, rs2, lat);
      issue(rop, rsel, rimm, rpc, rs1, rs2, r, lat);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
